// File: rtl/mem_data_unit.sv
// Load/store data path for the multicycle core: one request/ready bus transaction per access,
// with byte-lane steering for stores, size/sign extension for loads, and fault reporting.
module mem_data_unit #(
    parameter int WAIT_LIMIT     = 255,
    parameter int WAIT_CNT_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] data_buf,
    output logic        busy,
    output logic        done,
    output logic [1:0]  fault
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam logic [WAIT_CNT_WIDTH-1:0] LIMIT = WAIT_CNT_WIDTH'(WAIT_LIMIT);

    state_t                    r_state;
    logic [2:0]                r_funct3;
    logic [1:0]                r_off;
    logic [WAIT_CNT_WIDTH-1:0] r_cnt;
    logic                      r_req;
    logic                      r_we;
    logic [31:0]               r_addr;
    logic [3:0]                r_wstrb;
    logic [31:0]               r_wdata;
    logic [31:0]               r_data_buf;
    logic                      r_done;
    logic [1:0]                r_fault;

    logic                      w_illegal;
    logic                      w_misal;
    logic [3:0]                w_wstrb;
    logic [31:0]               w_wdata;
    logic [7:0]                w_byte;
    logic [15:0]               w_half;
    logic [31:0]               w_load;
    logic [WAIT_CNT_WIDTH-1:0] w_cnt_nxt;

    assign w_cnt_nxt = r_cnt + 1'b1;

    // Illegal funct3 takes priority over misalignment when both apply.
    always_comb begin
        w_illegal = 1'b0;
        w_misal   = 1'b0;
        if (is_store)
            w_illegal = funct3[2] || (funct3[1:0] == 2'b11);
        else
            w_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        if (funct3[1:0] == 2'b01)
            w_misal = addr[0];
        else if (funct3[1:0] == 2'b10)
            w_misal = (addr[1:0] != 2'b00);
    end

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = 32'h0;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    w_wdata = {4{store_data[7:0]}};
                    w_wstrb = 4'b0001 << addr[1:0];
                end
                2'b01: begin
                    w_wdata = {2{store_data[15:0]}};
                    w_wstrb = 4'b0011 << addr[1:0];
                end
                default: begin
                    w_wdata = store_data;
                    w_wstrb = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        w_byte = mem_rdata[7:0];
        case (r_off)
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            2'd3:    w_byte = mem_rdata[31:24];
            default: w_byte = mem_rdata[7:0];
        endcase
        w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'h0, w_byte};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_funct3   <= 3'b000;
            r_off      <= 2'b00;
            r_cnt      <= '0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 32'h0;
            r_wstrb    <= 4'b0000;
            r_wdata    <= 32'h0;
            r_data_buf <= 32'h0;
            r_done     <= 1'b0;
            r_fault    <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_funct3 <= funct3;
                        r_off    <= addr[1:0];
                        if (w_illegal) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_fault <= 2'b10;
                        end else if (w_misal) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_fault <= 2'b01;
                        end else begin
                            r_state <= S_REQ;
                            r_req   <= 1'b1;
                            r_we    <= is_store;
                            r_addr  <= {addr[31:2], 2'b00};
                            r_wstrb <= w_wstrb;
                            r_wdata <= w_wdata;
                        end
                    end
                end
                S_REQ: begin
                    // Ready wins over a timeout landing on the same cycle.
                    if (mem_ready) begin
                        r_state <= S_DONE;
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_fault <= 2'b00;
                        r_cnt   <= '0;
                        if (!r_we)
                            r_data_buf <= w_load;
                    end else if ((WAIT_LIMIT != 0) && (w_cnt_nxt == LIMIT)) begin
                        r_state <= S_DONE;
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_fault <= 2'b11;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_fault <= 2'b00;
                    r_cnt   <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wstrb = r_wstrb;
    assign mem_wdata = r_wdata;
    assign data_buf  = r_data_buf;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign fault     = r_fault;

endmodule
